mips_muldiv_sequencer: RTL and testbench



---
 rtl/mips_muldiv_pkg.sv | 30 +++
 rtl/mips_muldiv_step.sv | 35 +++
 rtl/mips_muldiv_sequencer.sv | 145 ++++++++++++++
 tb/tb_mips_muldiv_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS HI/LO multiply/divide sequencer.
package mips_muldiv_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_FIXUP = 2'd3
  } state_e;

  // Quotient reported for any divide by zero.
  localparam logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic funct_known(input logic [5:0] f);
    return f inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                     FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module mips_muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               mode,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH:0]     rem_in,
  input  logic [WIDTH-1:0]   operand,
  input  logic               mul_bit,
  output logic [2*WIDTH-1:0] acc_out,
  output logic [WIDTH:0]     rem_out
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // mode 0: acc = (acc + bit*mcand<<W) >> 1; mode 1: remainder in rem, dividend/quotient in acc low half
  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (mul_bit ? {1'b0, operand} : '0);
    shifted = {rem_in[WIDTH-1:0], acc_in[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, operand};
    acc_out = acc_in;
    rem_out = rem_in;
    if (!mode) begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end else if (diff[WIDTH+1]) begin
      rem_out = shifted;
      acc_out = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out = diff[WIDTH:0];
      acc_out = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mips_muldiv_sequencer.sv
// EX-stage HI/LO sequencer: iterative mult/div, owns HI and LO, stalls later HI/LO ops.
module mips_muldiv_sequencer
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int unsigned AW   = 2 * WIDTH;
  localparam int unsigned CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e            state;
  logic [CW-1:0]     count;
  logic [AW-1:0]     acc, acc_step, prod_fix;
  logic [WIDTH:0]    rem, rem_step;
  logic [WIDTH-1:0]  op_a, op_b, quo_fix, rem_fix;
  logic              neg_lo, neg_hi, is_div, is_signed, sign_diff;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? WIDTH'(-x) : x;
  endfunction

  assign is_signed = (funct == FN_MULT) || (funct == FN_DIV);
  assign sign_diff = is_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
  assign stall     = valid && funct_known(funct) && (state != ST_IDLE);

  always_comb begin
    result = '0;
    if (funct == FN_MFHI)      result = hi;
    else if (funct == FN_MFLO) result = lo;
  end

  // Sign fixup applied on the way into HI/LO.
  always_comb begin
    prod_fix = neg_lo ? AW'(-acc) : acc;
    quo_fix  = neg_lo ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix  = neg_hi ? WIDTH'(-rem[WIDTH-1:0]) : rem[WIDTH-1:0];
  end

  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode    (state == ST_DIV),
    .acc_in  (acc),
    .rem_in  (rem),
    .operand (op_a),
    .mul_bit (op_b[count]),
    .acc_out (acc_step),
    .rem_out (rem_step)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      rem    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid) begin
            case (funct)
              FN_MTHI: hi <= rs;
              FN_MTLO: lo <= rs;
              FN_MULT, FN_MULTU: begin
                op_a   <= magnitude(rs, is_signed);
                op_b   <= magnitude(rt, is_signed);
                neg_lo <= sign_diff;
                neg_hi <= 1'b0;
                is_div <= 1'b0;
                acc    <= '0;
                count  <= '0;
                state  <= ST_MUL;
                busy   <= 1'b1;
              end
              FN_DIV, FN_DIVU: begin
                is_div <= 1'b1;
                count  <= '0;
                busy   <= 1'b1;
                if (rt == '0) begin
                  acc    <= {{WIDTH{1'b0}}, WIDTH'(DIV0_LO)};
                  rem    <= {1'b0, rs};
                  neg_lo <= 1'b0;
                  neg_hi <= 1'b0;
                  state  <= ST_FIXUP;
                end else begin
                  op_a   <= magnitude(rt, is_signed);
                  acc    <= {{WIDTH{1'b0}}, magnitude(rs, is_signed)};
                  rem    <= '0;
                  neg_lo <= sign_diff;
                  neg_hi <= is_signed && rs[WIDTH-1];
                  state  <= ST_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          acc   <= acc_step;
          rem   <= rem_step;
          count <= count + 1'b1;
          if (count == LAST) state <= ST_FIXUP;
        end
        ST_FIXUP: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_sequencer.sv
// Self-checking bench: arithmetic/latency model compared every cycle, plus literal spot checks.
module tb_mips_muldiv_sequencer;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam int unsigned OP_CYCLES = 33;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  funct = 6'h0;
  logic [31:0] rs = 32'h0;
  logic [31:0] rt = 32'h0;
  logic        stall, busy;
  logic [31:0] result, hi, lo;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mips_muldiv_sequencer #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .valid   (valid),
    .funct   (funct),
    .rs      (rs),
    .rt      (rt),
    .flush   (flush),
    .stall   (stall),
    .busy    (busy),
    .result  (result),
    .hi      (hi),
    .lo      (lo)
  );

  // Model: plain 64-bit arithmetic plus a countdown to the HI/LO write.
  int unsigned left;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  function automatic logic known(input logic [5:0] f);
    return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  function automatic logic [63:0] op_result(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (f == F_MULT)  return sa * sb;
    if (f == F_MULTU) return {32'h0, a} * {32'h0, b};
    if (b == 32'h0)   return {a, 32'hFFFF_FFFF};
    if (f == F_DIV) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      left <= 0;
      m_hi <= 32'h0;
      m_lo <= 32'h0;
      p_hi <= 32'h0;
      p_lo <= 32'h0;
    end else if (flush) begin
      left <= 0;
    end else if (left != 0) begin
      left <= left - 1;
      if (left == 1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (valid) begin
      case (funct)
        F_MTHI: m_hi <= rs;
        F_MTLO: m_lo <= rs;
        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
          {p_hi, p_lo} <= op_result(funct, rs, rt);
          left <= ((funct == F_DIV || funct == F_DIVU) && rt == 32'h0) ? 1 : OP_CYCLES;
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic [31:0] e_res;
    e_res = (funct == F_MFHI) ? m_hi : (funct == F_MFLO) ? m_lo : 32'h0;
    check("busy",   32'(busy),  32'(left != 0));
    check("stall",  32'(stall), 32'(valid && known(funct) && left != 0));
    check("result", result, e_res);
    check("hi",     hi, m_hi);
    check("lo",     lo, m_lo);
  endtask

  // One clock: compare at the falling edge, then advance past the rising edge.
  task automatic tick();
    @(negedge clock);
    compare_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    valid = v;
    funct = f;
    rs    = a;
    rt    = b;
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    set_in(1'b1, f, a, b);
    tick();
    set_in(1'b0, 6'h0, 32'h0, 32'h0);
  endtask

  // Counts the cycles busy stays high after the accept; an expired bound is a failure.
  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (busy && n < 60) begin
      n++;
      tick();
    end
    check({name, "_timeout"}, 32'(busy), 32'h0);
  endtask

  task automatic wait_stall(input string name, output int n);
    n = 0;
    while (stall && n < 60) begin
      n++;
      tick();
    end
    check({name, "_timeout"}, 32'(stall), 32'h0);
  endtask

  int n;
  logic [31:0] keep_hi, keep_lo;

  initial begin
    @(posedge clock);
    #1;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_hi",   hi, 32'h0);
    check("reset_lo",   lo, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // mult 3 * -5: busy spans edges E0..E32, HI/LO land at E33
    issue(F_MULT, 32'd3, 32'hFFFF_FFFB);
    wait_idle("mult", n);
    check("mult_busy_cycles", 32'(n), 32'd33);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);

    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("multu", n);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div", n);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // divu 100/7 with an unrecognised funct presented while busy
    issue(F_DIVU, 32'd100, 32'd7);
    set_in(1'b1, 6'h20, 32'h0, 32'h0);
    check("unknown_no_stall", 32'(stall), 32'h0);
    repeat (3) tick();
    set_in(1'b0, 6'h0, 32'h0, 32'h0);
    wait_idle("divu", n);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    issue(F_DIVU, 32'd100, 32'd0);
    wait_idle("div0", n);
    check("div0_busy_cycles", 32'(n), 32'd1);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'd100);

    // dependent mflo right after a mult
    issue(F_MULT, 32'd7, 32'd6);
    set_in(1'b1, F_MFLO, 32'h0, 32'h0);
    wait_stall("mflo_dep", n);
    check("mflo_stall_cycles", 32'(n), 32'd33);
    check("mflo_result", result, 32'd42);
    tick();
    set_in(1'b0, 6'h0, 32'h0, 32'h0);

    issue(F_MTLO, 32'h1234, 32'h0);
    set_in(1'b1, F_MFLO, 32'h0, 32'h0);
    check("mtlo_mflo_stall", 32'(stall), 32'h0);
    check("mtlo_mflo_result", result, 32'h1234);
    tick();
    set_in(1'b0, 6'h0, 32'h0, 32'h0);

    // mtlo held behind a mult must land after the product
    issue(F_MULT, 32'd2, 32'd3);
    set_in(1'b1, F_MTLO, 32'h55, 32'h0);
    wait_stall("mtlo_held", n);
    tick();
    set_in(1'b0, 6'h0, 32'h0, 32'h0);
    check("mtlo_after_mult_lo", lo, 32'h55);
    check("mtlo_after_mult_hi", hi, 32'h0);

    // back-to-back mult: second accepted once the first retires
    issue(F_MULT, 32'd4, 32'd5);
    set_in(1'b1, F_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_stall("mult_b2b", n);
    check("mult_b2b_stall_cycles", 32'(n), 32'd33);
    check("mult_b2b_first_lo", lo, 32'd20);
    tick();
    set_in(1'b0, 6'h0, 32'h0, 32'h0);
    check("mult_b2b_accept", 32'(busy), 32'h1);
    wait_idle("mult_b2b2", n);
    check("mult_b2b_hi", hi, 32'hFFFF_FFFF);
    check("mult_b2b_lo", lo, 32'hFFFF_FFFA);

    // flush at cycle 10 of a div
    keep_hi = hi;
    keep_lo = lo;
    issue(F_DIV, 32'd1000, 32'd3);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_hi", hi, keep_hi);
    check("flush_lo", lo, keep_lo);
    issue(F_MULT, 32'h8000_0000, 32'hFFFF_FFFF);
    check("flush_new_accept", 32'(busy), 32'h1);
    wait_idle("mult_min", n);
    check("mult_min_hi", hi, 32'h0);
    check("mult_min_lo", lo, 32'h8000_0000);

    // flush in IDLE suppresses an mthi
    flush = 1'b1;
    issue(F_MTHI, 32'h77, 32'h0);
    flush = 1'b0;
    check("flush_idle_hi", hi, 32'h0);

    // async reset in the middle of a mult
    issue(F_MULT, 32'd9, 32'd9);
    repeat (19) tick();
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    issue(F_MTHI, 32'd5, 32'h0);
    check("mthi_after_rst", hi, 32'd5);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
